// File: rtl/binary_search_pkg.sv
`default_nettype none
// ============================================================================
// Module  : binary_search_pkg
// Brief   : Shared types, defaults and helpers for the binary_search block.
// Revision: 1.0 - initial release
// ============================================================================
package binary_search_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 1024;

    // Search controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bs_state_e;

    // Index width for a power-of-two table of the given depth
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : binary_search_pkg
`default_nettype wire

// File: rtl/bs_regfile.sv
`default_nettype none
// ============================================================================
// Module  : bs_regfile
// Brief   : DEPTH x DATA_WIDTH register file, one synchronous write port and
//           two combinational read ports (search probe and equality probe).
// Revision: 1.0 - initial release
// ============================================================================
module bs_regfile
    import binary_search_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int AW         = calc_aw(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]         rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Table contents are software-owned, so they carry no reset
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];

endmodule : bs_regfile
`default_nettype wire

// File: rtl/binary_search.sv
`default_nettype none
// ============================================================================
// Module  : binary_search
// Brief   : CPU-loaded sorted lookup table with a fixed-latency
//           successive-approximation search (one index bit per cycle).
// Revision: 1.0 - initial release
// ============================================================================
module binary_search
    import binary_search_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int AW         = calc_aw(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    output logic                  cpu_access_done,
    input  logic [DATA_WIDTH-1:0] request_key,
    input  logic                  request_key_valid,
    output logic [AW-1:0]         response_index,
    output logic                  response_valid,
    output logic                  no_match_found
);

    localparam logic [AW-1:0] c_top_bit = AW'(AW - 1);

    bs_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         bit_q, bit_d;
    logic                  access_done_q, access_done_d;
    logic                  response_valid_q, response_valid_d;
    logic                  no_match_q, no_match_d;
    logic [AW-1:0]         response_index_q, response_index_d;

    logic                  w_active;
    logic [AW-1:0]         w_cur_bit;
    logic [AW-1:0]         w_cur_idx;
    logic [DATA_WIDTH-1:0] w_cur_key;
    logic [AW-1:0]         w_cand;
    logic [AW-1:0]         w_idx_next;
    logic                  w_step_done;
    logic [DATA_WIDTH-1:0] w_cand_data;
    logic [DATA_WIDTH-1:0] w_final_data;

    bs_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .Clk       (Clk),
        .wr_en     (cpu_wr),
        .wr_addr   (cpu_addr),
        .wr_data   (cpu_data),
        .rd_addr_a (w_cand),
        .rd_data_a (w_cand_data),
        .rd_addr_b (w_idx_next),
        .rd_data_b (w_final_data)
    );

    // One search step: in IDLE the first step runs on the live key with idx=0,
    // afterwards on the latched key; the final probe reads the chosen index.
    always_comb begin
        w_active    = (state_q == ST_IDLE) ? request_key_valid : 1'b1;
        w_cur_bit   = (state_q == ST_IDLE) ? c_top_bit : bit_q;
        w_cur_idx   = (state_q == ST_IDLE) ? '0 : idx_q;
        w_cur_key   = (state_q == ST_IDLE) ? request_key : key_q;
        w_cand      = w_cur_idx | (AW'(1) << w_cur_bit);
        w_idx_next  = (w_cand_data <= w_cur_key) ? w_cand : w_cur_idx;
        w_step_done = w_active && (w_cur_bit == '0);
    end

    // Next-state for the controller, acknowledge and response registers
    always_comb begin
        state_d          = state_q;
        key_d            = key_q;
        idx_d            = idx_q;
        bit_d            = bit_q;
        access_done_d    = cpu_wr | cpu_rd;
        response_valid_d = 1'b0;
        no_match_d       = 1'b0;
        response_index_d = response_index_q;
        if (w_active) begin
            key_d = w_cur_key;
            idx_d = w_idx_next;
            bit_d = w_cur_bit - AW'(1);
            if (w_step_done) begin
                state_d          = ST_IDLE;
                response_valid_d = 1'b1;
                response_index_d = w_idx_next;
                no_match_d       = (w_final_data != w_cur_key);
            end else begin
                state_d = ST_BUSY;
            end
        end
    end

    // Register update; reset aborts any search in progress
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q          <= ST_IDLE;
            key_q            <= '0;
            idx_q            <= '0;
            bit_q            <= '0;
            access_done_q    <= 1'b0;
            response_valid_q <= 1'b0;
            no_match_q       <= 1'b0;
            response_index_q <= '0;
        end else begin
            state_q          <= state_d;
            key_q            <= key_d;
            idx_q            <= idx_d;
            bit_q            <= bit_d;
            access_done_q    <= access_done_d;
            response_valid_q <= response_valid_d;
            no_match_q       <= no_match_d;
            response_index_q <= response_index_d;
        end
    end

    assign cpu_access_done = access_done_q;
    assign response_valid  = response_valid_q;
    assign no_match_found  = no_match_q;
    assign response_index  = response_index_q;

endmodule : binary_search
`default_nettype wire

// File: tb/tb_binary_search.sv
`default_nettype none
// ============================================================================
// Module  : tb_binary_search
// Brief   : Scoreboard bench for binary_search against a linear-scan model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_binary_search;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int LAT   = AW - 1;

    logic          Clk;
    logic          Rst;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_wr;
    logic          cpu_rd;
    logic          cpu_access_done;
    logic [DW-1:0] request_key;
    logic          request_key_valid;
    logic [AW-1:0] response_index;
    logic          response_valid;
    logic          no_match_found;

    binary_search #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .cpu_addr          (cpu_addr),
        .cpu_data          (cpu_data),
        .cpu_wr            (cpu_wr),
        .cpu_rd            (cpu_rd),
        .cpu_access_done   (cpu_access_done),
        .request_key       (request_key),
        .request_key_valid (request_key_valid),
        .response_index    (response_index),
        .response_valid    (response_valid),
        .no_match_found    (no_match_found)
    );

    typedef struct {
        logic [AW-1:0] idx;
        logic          nm;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    bit            mon_en   = 0;
    logic          ack_exp  = 1'b0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Any accepted CPU strobe must be acknowledged on the next cycle only
    always @(posedge Clk) ack_exp <= Rst ? 1'b0 : (cpu_wr | cpu_rd);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation
    always @(negedge Clk) begin
        if (mon_en) begin
            check("cpu_access_done", {63'd0, cpu_access_done}, {63'd0, ack_exp});
            if (response_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_response: got index %0d with nothing expected (cycle %0d)",
                             response_index, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("response_index", {54'd0, response_index}, {54'd0, e.idx});
                    check("no_match_found", {63'd0, no_match_found}, {63'd0, e.nm});
                    check("response_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Reference: highest index whose entry is <= key, else 0
    function automatic void ref_search(input logic [DW-1:0] key,
                                       output logic [AW-1:0] idx, output logic nm);
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (model[i] <= key) begin
                idx = AW'(i);
                break;
            end
        end
        nm = (model[idx] != key);
    endfunction

    task automatic write_word(input int addr, input logic [DW-1:0] data);
        @(negedge Clk);
        cpu_wr   = 1'b1;
        cpu_addr = AW'(addr);
        cpu_data = data;
        model[addr] = data;
    endtask

    task automatic end_writes();
        @(negedge Clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic issue(input logic [DW-1:0] key, input bit expect_resp);
        exp_t          e;
        logic [AW-1:0] idx;
        logic          nm;
        @(negedge Clk);
        request_key       = key;
        request_key_valid = 1'b1;
        @(posedge Clk);
        #1;
        if (expect_resp) begin
            ref_search(key, idx, nm);
            e.idx = idx;
            e.nm  = nm;
            e.cyc = cyc + LAT;
            sb.push_back(e);
        end
        @(negedge Clk);
        request_key_valid = 1'b0;
        request_key       = $urandom;
    endtask

    task automatic search(input logic [DW-1:0] key);
        issue(key, 1'b1);
        repeat (AW + 1) @(posedge Clk);
    endtask

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] k;
        Rst = 1'b1;
        cpu_addr = '0;
        cpu_data = '0;
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        request_key = '0;
        request_key_valid = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_response_valid", {63'd0, response_valid}, 64'd0);
        check("rst_no_match", {63'd0, no_match_found}, 64'd0);
        check("rst_response_index", {54'd0, response_index}, 64'd0);
        check("rst_access_done", {63'd0, cpu_access_done}, 64'd0);
        Rst = 1'b0;
        mon_en = 1'b1;

        // CPU handshake: single write, lone read, then quiet cycles
        write_word(5, 32'hA);
        end_writes();
        @(negedge Clk);
        cpu_rd = 1'b1;
        end_writes();
        repeat (3) @(posedge Clk);

        // Even-number table
        for (int i = 0; i < DEPTH; i++) write_word(i, DW'(2 * i));
        end_writes();
        search(32'd74);
        search(32'd75);
        search(32'd0);
        search(32'd2046);

        // Offset table: both out-of-range ends, then a write with rd also high
        for (int i = 0; i < DEPTH; i++) write_word(i, DW'(i + 100));
        end_writes();
        search(32'd5);
        search(32'hFFFF_FFFF);
        @(negedge Clk);
        cpu_wr = 1'b1;
        cpu_rd = 1'b1;
        cpu_addr = '0;
        cpu_data = '0;
        model[0] = '0;
        end_writes();
        search(32'd0);
        search(32'd5);

        // Duplicate run at 10..12
        for (int i = 0; i < DEPTH; i++)
            write_word(i, (i < 10) ? DW'(i) : (i <= 12) ? 32'h30 : DW'(i + 32'h30));
        end_writes();
        search(32'h30);

        // Busy request ignored, then a back-to-back request
        issue(32'h31, 1'b1);
        @(negedge Clk);
        request_key_valid = 1'b1;
        request_key = 32'd3;
        repeat (3) @(negedge Clk);
        request_key_valid = 1'b0;
        repeat (5) @(posedge Clk);
        issue(32'd11, 1'b1);
        repeat (LAT) @(posedge Clk);
        issue(32'h30, 1'b1);
        repeat (AW + 1) @(posedge Clk);

        // Reset on the fifth edge of a search aborts it
        issue(32'h40, 1'b0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("abort_response_valid", {63'd0, response_valid}, 64'd0);
        check("abort_no_match", {63'd0, no_match_found}, 64'd0);
        check("abort_response_index", {54'd0, response_index}, 64'd0);
        check("abort_access_done", {63'd0, cpu_access_done}, 64'd0);
        Rst = 1'b0;
        repeat (AW + 2) @(posedge Clk);
        search(32'h40);

        // Random sorted tables with duplicates and random keys
        for (int t = 0; t < 3; t++) begin
            v = $urandom & 32'h7FFF_0000;
            for (int i = 0; i < DEPTH; i++) begin
                write_word(i, v);
                v = v + DW'($urandom_range(0, 3));
            end
            end_writes();
            for (int n = 0; n < 16; n++) begin
                case ($urandom_range(0, 3))
                    0:       k = model[$urandom_range(0, DEPTH - 1)];
                    1:       k = model[$urandom_range(0, DEPTH - 1)] + 1;
                    2:       k = $urandom;
                    default: k = model[0] + DW'($urandom_range(0, 4000)) - 2;
                endcase
                search(k);
            end
        end

        for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge Clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_response: %0d responses outstanding, expected 0", sb.size());
        end
        repeat (2) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_binary_search
`default_nettype wire

// File: doc/binary_search.md
Name: binary_search

Overview:
- Searchable lookup table. Software loads a sorted array of DEPTH words over a simple CPU write port.
- A requestor then submits a key. The block performs a fixed-latency binary search and returns the matching index or a no-match flag.
- Sits between a CPU configuration bus and a single requestor; one search in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of each stored word and of the key.
- DEPTH, 1024, number of entries; must be a power of two, at least 2.
- Derived localparam AW = $clog2(DEPTH), the index width (10 at default).

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, synchronous, active-high; clock Clk.
- cpu_addr  in  AW  write/read address.
- cpu_data  in  DATA_WIDTH  write data.
- cpu_wr  in  1  write strobe, sampled each Clk edge.
- cpu_rd  in  1  read strobe; acknowledged only, since there is no read-data port.
- cpu_access_done  out  1  one-cycle acknowledge for cpu_wr/cpu_rd.
- request_key  in  DATA_WIDTH  key to search for.
- request_key_valid  in  1  start a search, sampled each edge.
- response_index  out  AW  result index.
- response_valid  out  1  one-cycle result strobe.
- no_match_found  out  1  qualifies response_valid: key not present.

Behaviour:
- Reset values: cpu_access_done, response_valid, no_match_found, response_index all 0; FSM enters IDLE. Memory contents are not reset (undefined until written).
- Reset mid-search aborts the search; no response is issued.
- Storage is a register file with 1 synchronous write port and 2 combinational read ports, so one probe completes per cycle.
- CPU write: on an edge with cpu_wr=1, mem[cpu_addr] <= cpu_data. cpu_access_done=1 for exactly the following cycle.
- CPU read: cpu_rd alone also gives a one-cycle cpu_access_done, with no other effect. If cpu_wr and cpu_rd are both high, the access is treated as a write.
- Writes are accepted in any state. Writing while a search is BUSY yields an undefined result; software must not do so.
- Array contract: entries are in ascending unsigned order. Result for unsorted contents is undefined, but the latency is still fixed.
- FSM states:
  - IDLE: on an edge with request_key_valid=1, latch the key, set idx=0, and perform step b=AW-1 using request_key directly. Go to BUSY.
  - BUSY: one step per edge for b=AW-2 down to 0. request_key_valid is ignored while BUSY (no queueing).
- Successive-approximation step for bit b: cand = idx | (1<<b); if mem[cand] <= key then idx <= cand.
- Completion at the step b=0 edge:
  - final = chosen idx.
  - response_index <= final.
  - response_valid <= 1 for one cycle.
  - no_match_found <= (mem[final] != key), also one cycle.
  - Return to IDLE.
- Latency: the response is registered on exactly the AW-th edge, counting the edge that sampled request_key_valid as the first (10 edges at default). A new request may be sampled on the edge after the response edge.
- Result semantics: final = highest index with mem[final] <= key, or 0 if none.
  - Duplicates return the highest matching index.
  - Key below mem[0] gives no_match with index 0.
  - Key above mem[DEPTH-1] gives no_match with index DEPTH-1.
  - No early termination on equality.
- response_index holds its value until the next response.
- All comparisons are unsigned, DATA_WIDTH bits.

Decomposition:
- Package binary_search_pkg holds:
  - the FSM state enum (IDLE, BUSY);
  - a constant function for AW;
  - default DATA_WIDTH/DEPTH constants.
- One sub-module, bs_regfile: DEPTH x DATA_WIDTH, 1 write port and 2 asynchronous read ports (candidate probe and final-equality probe).
- The top holds the CPU acknowledge logic, FSM, idx/bit counter and output registers.

Test Plan:
- CPU write handshake: pulse cpu_wr with addr 5, data 0xA; cpu_access_done is high exactly one cycle after the sampling edge and low otherwise. cpu_rd alone gives the same one-cycle ack.
- Load mem[i]=2*i for i=0..1023, then request key 74: response_index=37, no_match_found=0, response_valid on exactly the 10th edge after the sampling edge counting it as 1, single cycle.
- Same array, key 75: no_match_found=1, response_index=37. Key 0 gives index 0, match. Key 2046 gives index 1023, match.
- Boundaries: load mem[i]=i+100, then key 5 gives no_match with index 0; key 0xFFFFFFFF gives no_match with index 1023. Duplicates: mem[10..12]=0x30, key 0x30 gives index 12.
- Busy and back-to-back: a second request_key_valid during BUSY is ignored with no extra response. A request on the edge after response_valid is accepted and answered 10 edges later.
- Reset mid-search: assert Rst on edge 5 of a search; no response_valid appears. All outputs are 0, and the next request behaves normally (memory retained).
